// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined IEEE-754 style add/sub with RNE,
// special values, exception flags and a stalling valid/ready handshake.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            invalid,
  output logic            inexact
);
  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(MAN_W + 5);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
  localparam logic [XLEN-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sgn;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    ma;
    logic [SW-1:0]    mb;
    logic             spc;
    logic             inv;
    logic [XLEN-1:0]  sres;
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic             spc;
    logic             inv;
    logic [XLEN-1:0]  sres;
  } s2_t;

  logic r_v1, r_v2;
  s1_t  r_s1;
  s2_t  r_s2;
  logic w_adv;

  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  logic [EXP_W-1:0]   w_ea, w_eb, w_el, w_es, w_diff;
  logic [MAN_W-1:0]   w_fa, w_fb, w_fl, w_fs;
  logic               w_sa, w_sb, w_za, w_zb, w_zs;
  logic               w_ia, w_ib, w_na, w_nb, w_swap;
  logic [2*MAN_W+2:0] w_ext;
  s1_t                w_s1;

  assign w_sa   = a[XLEN-1];
  assign w_sb   = b[XLEN-1] ^ op;
  assign w_ea   = a[XLEN-2 -: EXP_W];
  assign w_eb   = b[XLEN-2 -: EXP_W];
  assign w_za   = (w_ea == '0);
  assign w_zb   = (w_eb == '0);
  assign w_fa   = w_za ? '0 : a[MAN_W-1:0];
  assign w_fb   = w_zb ? '0 : b[MAN_W-1:0];
  assign w_ia   = (w_ea == EMAX) && (w_fa == '0);
  assign w_ib   = (w_eb == EMAX) && (w_fb == '0);
  assign w_na   = (w_ea == EMAX) && (w_fa != '0);
  assign w_nb   = (w_eb == EMAX) && (w_fb != '0);
  assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_el   = w_swap ? w_eb : w_ea;
  assign w_es   = w_swap ? w_ea : w_eb;
  assign w_fl   = w_swap ? w_fb : w_fa;
  assign w_fs   = w_swap ? w_fa : w_fb;
  assign w_zs   = w_swap ? w_za : w_zb;
  assign w_diff = w_el - w_es;
  // low MAN_W bits of the shifted window collapse into sticky
  assign w_ext  = {~w_zs, w_fs, {(MAN_W+2){1'b0}}} >> w_diff;

  always_comb begin
    w_s1      = '0;
    w_s1.sgn  = w_swap ? w_sb : w_sa;
    w_s1.sub  = w_sa ^ w_sb;
    w_s1.exp  = w_el;
    w_s1.ma   = {1'b1, w_fl, 3'b000};
    if (32'(w_diff) >= 32'(MAN_W + 3))
      w_s1.mb = {{(SW-1){1'b0}}, ~w_zs};
    else
      w_s1.mb = {w_ext[2*MAN_W+2 -: MAN_W+3], |w_ext[MAN_W-1:0]};
    w_s1.spc  = 1'b1;
    w_s1.sres = QNAN;
    if (w_na || w_nb)
      w_s1.inv = 1'b1;
    else if (w_ia && w_ib && (w_sa != w_sb))
      w_s1.inv = 1'b1;
    else if (w_ia)
      w_s1.sres = a;
    else if (w_ib)
      w_s1.sres = {w_sb, b[XLEN-2:0]};
    else if (w_za && w_zb)
      w_s1.sres = {w_sa & w_sb, {(XLEN-1){1'b0}}};
    else if (w_za)
      w_s1.sres = {w_sb, b[XLEN-2:0]};
    else if (w_zb)
      w_s1.sres = a;
    else
      w_s1.spc = 1'b0;
  end

  s2_t w_s2;

  always_comb begin
    w_s2      = '0;
    w_s2.sgn  = r_s1.sgn;
    w_s2.exp  = r_s1.exp;
    w_s2.sum  = r_s1.sub ? ({1'b0, r_s1.ma} - {1'b0, r_s1.mb})
                         : ({1'b0, r_s1.ma} + {1'b0, r_s1.mb});
    w_s2.spc  = r_s1.spc;
    w_s2.inv  = r_s1.inv;
    w_s2.sres = r_s1.sres;
  end

  logic [LZW-1:0]        w_lz;
  logic                  w_found;
  logic [SW-1:0]         w_norm;
  logic signed [EW-1:0]  w_en, w_ef;
  logic                  w_inc;
  logic [MAN_W+1:0]      w_mr;
  logic [MAN_W-1:0]      w_mf;
  logic [XLEN-1:0]       w_res;
  logic                  w_ovf, w_unf, w_inv, w_inx;

  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_s2.sum[i]) w_found = 1'b1;
        else             w_lz    = w_lz + LZW'(1);
      end
    end
    if (r_s2.sum[SW]) begin
      w_norm = {r_s2.sum[SW:2], |r_s2.sum[1:0]};
      w_en   = EW'(r_s2.exp) + EW'(1);
    end else begin
      w_norm = r_s2.sum[SW-1:0] << w_lz;
      w_en   = EW'(r_s2.exp) - EW'(w_lz);
    end
    w_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mr  = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_inc);
    w_ef  = w_en + EW'(w_mr[MAN_W+1]);
    w_mf  = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
    w_res = {r_s2.sgn, w_ef[EXP_W-1:0], w_mf};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    w_inx = |w_norm[2:0];
    if (r_s2.spc) begin
      w_res = r_s2.sres;
      w_inv = r_s2.inv;
      w_inx = 1'b0;
    end else if (r_s2.sum == '0) begin
      w_res = '0;
      w_inx = 1'b0;
    end else if (w_ef >= EMAX_S) begin
      w_res = {r_s2.sgn, EMAX, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_ef[EW-1] || (w_ef == '0)) begin
      w_res = {r_s2.sgn, {(XLEN-1){1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (w_adv) begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      r_s1      <= w_s1;
      r_s2      <= w_s2;
      result    <= r_v2 ? w_res : '0;
      overflow  <= r_v2 & w_ovf;
      underflow <= r_v2 & w_unf;
      invalid   <= r_v2 & w_inv;
      inexact   <= r_v2 & w_inx;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: vector table streamed through a scoreboard, plus
// latency, backpressure and mid-stream reset sequences.
module tb_fp_addsub_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, invalid, inexact;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        done = 1'b0;
  logic [35:0] sb_q[$];
  vec_t        vecs[29];

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no output", result);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e[35:4]);
        chk("flags", {overflow, underflow, invalid, inexact}, e[3:0]);
      end
    end else if (!out_valid) begin
      chk("idle_flags", {overflow, underflow, invalid, inexact}, 4'b0);
    end
  end

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    a = v.a;
    b = v.b;
    op = v.op;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      sb_q.push_back({v.res, v.flg});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[7]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[9]  = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[10] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
    vecs[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[12] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101};
    vecs[13] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0101};
    vecs[14] = '{32'h41200000, 32'hC1200000, 1'b0, 32'h00000000, 4'b0000};
    vecs[15] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[16] = '{32'h3F800001, 32'h3F800001, 1'b0, 32'h40000001, 4'b0000};
    vecs[17] = '{32'h4B7FFFFF, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0000};
    vecs[18] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001};
    vecs[19] = '{32'h4B800001, 32'h3F800000, 1'b0, 32'h4B800002, 4'b0001};
    vecs[20] = '{32'h3FFFFFFF, 32'h33C00000, 1'b0, 32'h40000000, 4'b0001};
    vecs[21] = '{32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 4'b0000};
    vecs[22] = '{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b0010};
    vecs[23] = '{32'h7F7FFFFF, 32'h3F800000, 1'b0, 32'h7F7FFFFF, 4'b0001};
    vecs[24] = '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 4'b0010};
    vecs[25] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
    vecs[26] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
    vecs[27] = '{32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 4'b0000};
    vecs[28] = '{32'h7F7FFFFF, 32'h73800000, 1'b0, 32'h7F800000, 4'b1001};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {overflow, underflow, invalid, inexact}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    send(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_edge2", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_edge3", out_valid, 1);
    drain();

    foreach (vecs[i]) send(vecs[i]);
    idle();
    drain();

    done = 1'b0;
    fork
      begin
        foreach (vecs[i]) send(vecs[i]);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    fork
      begin
        for (int i = 10; i < 14; i++) send(vecs[i]);
        idle();
      end
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          #1;
          chk("stall_in_ready", in_ready, c < 3);
          chk("stall_out_valid", out_valid, c >= 3);
          if (c >= 3) chk("stall_hold", result, vecs[10].res);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    send(vecs[0]);
    send(vecs[1]);
    send(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("no_stale", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);

    send(vecs[7]);
    idle();
    drain();
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
